done_arbiter: RTL and testbench
===============================

# done_arbiter

Back-end completion transmitter for the transaction-controller done interface. Each of the 16 bank schedulers pushes finished transactions (read data or write acknowledge) into a small per-bank queue. The block arbitrates round-robin across banks and drives one completion per cycle onto `request_done_valid` / `the_type` / `in_data` / `index` toward `txn_controller`. That interface has no back-pressure, so all buffering and flow control live here.

## Interface
- `BANKS`, 16, number of bank sources; must be a power of two.
- `DATA_W`, 32, completion data width.
- `INDEX_W`, 6, transaction index width; matches `txn_controller` `index`.
- `DEPTH`, 2, entries per bank queue; must be a power of two, at least 2.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `bank_done_valid`  in  [0:BANKS-1]  per-bank completion push.
- `bank_done_type`  in  BANKS x r_type  `read` / `write` per bank (types_def).
- `bank_done_data`  in  BANKS x DATA_W  read data; don't-care for writes.
- `bank_done_index`  in  BANKS x INDEX_W  transaction index.
- `bank_done_ready`  out  [0:BANKS-1]  queue not full.
- `request_done_valid`  out  1  completion valid this cycle.
- `the_type`  out  r_type  type of the emitted completion.
- `in_data`  out  DATA_W  data of the emitted completion; forced to 0 for writes.
- `index`  out  INDEX_W  index of the emitted completion.
- `overflow_err`  out  1  sticky; set when a bank pushes while its queue is full.
- `done_count`  out  16  wrapping count of emitted completions.

## Operation
- **Per-bank queue.** Each bank has a FIFO with `DEPTH` entries (write pointer, read pointer, count of width log2(DEPTH)+1).
  - Push condition: `bank_done_valid[b] && bank_done_ready[b]`.
  - `bank_done_ready[b] = (count_b != DEPTH)`. It is combinational from the registered count only, never from the same-cycle pop.
- **Push on full queue.** A push is dropped and `overflow_err` is set. It stays set until reset.
- **Arbitration.** Request vector = queue not empty, per bank. Round-robin pointer `rr` has width log2(BANKS).
  - The grant goes to the first requesting bank at or after `rr`, wrapping modulo BANKS.
  - After a grant to bank k, `rr` becomes (k+1) mod BANKS.
  - With no request, `rr` holds.
- **Emit.** The granted bank's head entry is popped and registered onto the output signals in the same edge. `request_done_valid` = 1 for exactly that cycle.
  - At most one completion is emitted per cycle.
  - When no completion is emitted, `request_done_valid` = 0 and the other outputs hold their last values. `in_data` for writes is the exception: it is 0.
- **Simultaneous push and pop on the same bank.** Both take effect and the count is unchanged. A push into a queue holding DEPTH-1 entries while that bank is popped is legal.
- **`done_count`.** Increments on every emitted completion and wraps from 0xFFFF to 0.

## Timing
- **Reset (`rst` = 0, asynchronous).** All queues empty, `rr` = 0.
  - `request_done_valid` = 0, `the_type` = `read`, `in_data` = 0, `index` = 0, `overflow_err` = 0, `done_count` = 0.
  - `bank_done_ready` = all ones.
- **Reset mid-operation.** Queued entries are discarded. No completion is emitted during reset.
- **Latency.** A push at edge N into an empty queue with no competing requests produces `request_done_valid` = 1 in the cycle after edge N+1. This is 1 cycle of pipeline.
- **Throughput.** One completion per cycle overall.
- **Fairness.** With all banks continuously requesting, each bank is served exactly once per BANKS cycles.
- **Ready update.** `bank_done_ready[b]` deasserts in the cycle after the push that fills the queue. It reasserts in the cycle after the pop that frees an entry.

## Test plan
- **Reset values.** Assert `rst` low for 10 cycles, then release → every output holds its reset value, and `bank_done_ready` = 16'hFFFF.
- **Single read.** Bank 3 pushes `read`, data 10, index 5, for one cycle → exactly one `request_done_valid` pulse 1 cycle later, with `the_type` = `read`, `in_data` = 10, `index` = 5. `done_count` = 1.
- **Round-robin.** All 16 banks push a `write` with index = bank number in the same cycle → 16 consecutive valid cycles, indices 0,1,…,15 in order, `in_data` = 0 each time, `done_count` = 16.
- **Fairness.** Banks 0 and 1 push every cycle they are ready, for 64 cycles → emitted indices alternate between bank 0 and bank 1 entries, and `overflow_err` stays 0.
- **Overflow.** With no grants reaching bank 7 (banks 0-6 kept saturated), bank 7 pushes 3 entries while `bank_done_ready[7]` = 0 on the third push → `overflow_err` = 1, only 2 bank-7 completions are ever emitted, and `overflow_err` stays 1 until `rst`.
- **Reset mid-stream.** Pulse `rst` low with 5 entries queued → no completion is emitted after release, and `done_count` = 0.

Source files
------------

// File: rtl/done_arbiter_if.sv
// Completion types plus the bank-push / completion-emit bus seen by done_arbiter.
package types_def;
   typedef enum logic {read = 1'b0, write = 1'b1} r_type;
endpackage

interface done_arbiter_if
   import types_def::*;
#(
   parameter int BANKS   = 16,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 6
);
   logic [0:BANKS-1]   bank_done_valid;
   r_type              bank_done_type  [BANKS];
   logic [DATA_W-1:0]  bank_done_data  [BANKS];
   logic [INDEX_W-1:0] bank_done_index [BANKS];
   logic [0:BANKS-1]   bank_done_ready;

   logic               request_done_valid;
   r_type              the_type;
   logic [DATA_W-1:0]  in_data;
   logic [INDEX_W-1:0] index;

   // Bank schedulers / completion consumer side.
   modport master (
      output bank_done_valid, bank_done_type, bank_done_data, bank_done_index,
      input  bank_done_ready, request_done_valid, the_type, in_data, index
   );

   // Arbiter side.
   modport slave (
      input  bank_done_valid, bank_done_type, bank_done_data, bank_done_index,
      output bank_done_ready, request_done_valid, the_type, in_data, index
   );
endinterface

// File: rtl/done_arbiter.sv
// Per-bank completion queues, round-robin onto one registered done port; push-to-valid is 1 cycle.
// No back-pressure downstream: banks are throttled by queue-full ready, pushes into a full queue drop and set overflow_err.
module done_arbiter
   import types_def::*;
#(
   parameter int BANKS   = 16,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 6,
   parameter int DEPTH   = 2
) (
   input  logic          clk,
   input  logic          rst,
   done_arbiter_if.slave bus,
   output logic          overflow_err,
   output logic [15:0]   done_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(BANKS);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      r_type              typ;
      logic [DATA_W-1:0]  dat;
      logic [INDEX_W-1:0] idx;
   } entry_t;

   entry_t           mem  [BANKS][DEPTH];
   logic [AW-1:0]    wptr [BANKS];
   logic [AW-1:0]    rptr [BANKS];
   logic [AW:0]      cnt  [BANKS];

   logic [0:BANKS-1] ready;
   logic [BANKS-1:0] push;
   logic [BANKS-1:0] pop;
   logic [BANKS-1:0] req;
   logic             overflow_hit;
   logic [BW-1:0]    rr;
   logic [BW-1:0]    cand;
   logic [BW-1:0]    gnt_idx;
   logic             gnt_vld;
   entry_t           head;

   logic               out_vld;
   r_type              out_type;
   logic [DATA_W-1:0]  out_data;
   logic [INDEX_W-1:0] out_index;

   // Ready looks only at the registered count so a same-cycle pop never opens a slot.
   always_comb begin
      ready        = '0;
      push         = '0;
      req          = '0;
      overflow_hit = 1'b0;
      for (int b = 0; b < BANKS; b++) begin
         ready[b] = (cnt[b] != FULL);
         push[b]  = bus.bank_done_valid[b] && ready[b];
         req[b]   = (cnt[b] != '0);
         if (bus.bank_done_valid[b] && !ready[b])
            overflow_hit = 1'b1;
      end
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = rr;
      cand    = '0;
      for (int i = 0; i < BANKS; i++) begin
         cand = rr + BW'(i);
         if (!gnt_vld && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int b = 0; b < BANKS; b++)
         pop[b] = gnt_vld && (gnt_idx == BW'(b));
      head = mem[gnt_idx][rptr[gnt_idx]];
   end

   always_ff @(posedge clk) begin
      for (int b = 0; b < BANKS; b++) begin
         if (push[b])
            mem[b][wptr[b]] <= '{typ: bus.bank_done_type[b],
                                 dat: bus.bank_done_data[b],
                                 idx: bus.bank_done_index[b]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < BANKS; b++) begin
            wptr[b] <= '0;
            rptr[b] <= '0;
            cnt[b]  <= '0;
         end
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            if (push[b])
               wptr[b] <= wptr[b] + AW'(1);
            if (pop[b])
               rptr[b] <= rptr[b] + AW'(1);
            if (push[b] && !pop[b])
               cnt[b] <= cnt[b] + (AW+1)'(1);
            else if (!push[b] && pop[b])
               cnt[b] <= cnt[b] - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr           <= '0;
         out_vld      <= 1'b0;
         out_type     <= read;
         out_data     <= '0;
         out_index    <= '0;
         done_count   <= '0;
         overflow_err <= 1'b0;
      end else begin
         out_vld      <= gnt_vld;
         overflow_err <= overflow_err | overflow_hit;
         if (gnt_vld) begin
            rr         <= gnt_idx + BW'(1);
            out_type   <= head.typ;
            out_data   <= (head.typ == write) ? '0 : head.dat;
            out_index  <= head.idx;
            done_count <= done_count + 16'd1;
         end
      end
   end

   assign bus.bank_done_ready    = ready;
   assign bus.request_done_valid = out_vld;
   assign bus.the_type           = out_type;
   assign bus.in_data            = out_data;
   assign bus.index              = out_index;
endmodule

// File: tb/tb_done_arbiter.sv
// Directed scoreboard bench for done_arbiter: stimulus queues expected completions, a negedge monitor pops and compares.
module tb_done_arbiter;
   import types_def::*;

   localparam int BANKS   = 16;
   localparam int DATA_W  = 32;
   localparam int INDEX_W = 6;

   typedef struct {
      r_type              typ;
      logic [DATA_W-1:0]  dat;
      logic [INDEX_W-1:0] idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        overflow_err;
   logic [15:0] done_count;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   done_arbiter_if #(.BANKS(BANKS), .DATA_W(DATA_W), .INDEX_W(INDEX_W)) bus ();

   done_arbiter #(.BANKS(BANKS), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .overflow_err (overflow_err),
      .done_count   (done_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && bus.request_done_valid) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: got 1 expected 0 (index %0d)", bus.index);
         end else begin
            e = sb.pop_front();
            check("out_type",  32'(bus.the_type), 32'(e.typ));
            check("out_data",  bus.in_data,       e.dat);
            check("out_index", 32'(bus.index),    32'(e.idx));
         end
      end
   end

   task automatic idle_bus();
      bus.bank_done_valid = '0;
   endtask

   task automatic drive(input int b, input r_type t, input logic [31:0] d, input logic [5:0] i);
      bus.bank_done_valid[b] = 1'b1;
      bus.bank_done_type[b]  = t;
      bus.bank_done_data[b]  = d;
      bus.bank_done_index[b] = i;
   endtask

   task automatic expect_out(input r_type t, input logic [31:0] d, input logic [5:0] i);
      exp_t e;
      e.typ = t;
      e.dat = (t == write) ? 32'd0 : d;
      e.idx = i;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      idle_bus();
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
      check(name, 32'(sb.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int seq0;
      int seq1;
      idle_bus();
      for (int b = 0; b < BANKS; b++) drive(b, read, 32'd0, 6'd0);
      idle_bus();

      // Reset values
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_valid",    32'(bus.request_done_valid), 32'd0);
      check("rst_type",     32'(bus.the_type),           32'(read));
      check("rst_data",     bus.in_data,                 32'd0);
      check("rst_index",    32'(bus.index),              32'd0);
      check("rst_overflow", 32'(overflow_err),           32'd0);
      check("rst_count",    32'(done_count),             32'd0);
      check("rst_ready",    32'(bus.bank_done_ready),    32'h0000_FFFF);

      // Single read from bank 3: valid in the cycle after the next edge
      @(posedge clk); #1;
      drive(3, read, 32'd10, 6'd5);
      expect_out(read, 32'd10, 6'd5);
      @(posedge clk); #1 idle_bus();
      @(negedge clk);
      check("lat_early", 32'(bus.request_done_valid), 32'd0);
      @(negedge clk);
      check("lat_pulse", 32'(bus.request_done_valid), 32'd1);
      wait_drain("single_drain");
      check("single_count", 32'(done_count), 32'd1);

      // Round-robin: 16 writes at once, emitted 0..15 back to back with data forced to 0
      do_reset();
      @(posedge clk); #1;
      for (int b = 0; b < BANKS; b++) begin
         drive(b, write, 32'hDEAD_0000 + 32'(b), 6'(b));
         expect_out(write, 32'd0, 6'(b));
      end
      @(posedge clk); #1 idle_bus();
      @(negedge clk);
      for (int i = 0; i < BANKS; i++) begin
         @(negedge clk);
         check("rr_burst_valid", 32'(bus.request_done_valid), 32'd1);
      end
      @(negedge clk);
      check("rr_burst_end", 32'(bus.request_done_valid), 32'd0);
      wait_drain("rr_drain");
      check("rr_count", 32'(done_count), 32'd16);

      // Fairness: banks 0 and 1 push whenever ready; emission alternates 0,1,0,1...
      do_reset();
      for (int i = 0; i < 64; i++)
         expect_out(read, 32'h100 + 32'((i % 2) * 256 + i / 2), 6'((i % 2) * 32 + i / 2));
      seq0 = 0;
      seq1 = 0;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 200 && (seq0 < 32 || seq1 < 32); cyc++) begin
         idle_bus();
         if (bus.bank_done_ready[0] && seq0 < 32) begin
            drive(0, read, 32'h100 + 32'(seq0), 6'(seq0));
            seq0++;
         end
         if (bus.bank_done_ready[1] && seq1 < 32) begin
            drive(1, read, 32'h100 + 32'(256 + seq1), 6'(32 + seq1));
            seq1++;
         end
         @(posedge clk); #1;
      end
      idle_bus();
      wait_drain("fair_drain");
      check("fair_overflow", 32'(overflow_err), 32'd0);
      check("fair_count",    32'(done_count),   32'd64);

      // Overflow: banks 0-7 each queue two entries, bank 7 pushes a third while full
      do_reset();
      for (int s = 0; s < 2; s++)
         for (int b = 0; b < 8; b++)
            expect_out((b % 2) ? write : read, 32'h7000 + 32'(b * 4 + s), 6'(b * 4 + s));
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         check("ovf_ready7_open", 32'(bus.bank_done_ready[7]), 32'd1);
         for (int b = 0; b < 8; b++)
            drive(b, (b % 2) ? write : read, 32'h7000 + 32'(b * 4 + s), 6'(b * 4 + s));
         @(posedge clk); #1 idle_bus();
      end
      check("ovf_ready7_full", 32'(bus.bank_done_ready[7]), 32'd0);
      drive(7, write, 32'h7000 + 32'd30, 6'd30);
      @(posedge clk); #1 idle_bus();
      @(negedge clk);
      check("ovf_set", 32'(overflow_err), 32'd1);
      wait_drain("ovf_drain");
      check("ovf_sticky",      32'(overflow_err),          32'd1);
      check("ovf_count",       32'(done_count),            32'd16);
      check("ovf_ready7_back", 32'(bus.bank_done_ready[7]), 32'd1);

      // Reset mid-stream with 5 entries queued: nothing emerges afterwards
      @(posedge clk); #1;
      for (int b = 8; b < 13; b++) drive(b, read, 32'h55 + 32'(b), 6'(b));
      @(posedge clk); #1;
      idle_bus();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_count",    32'(done_count),         32'd0);
      check("mid_overflow", 32'(overflow_err),       32'd0);
      check("mid_ready",    32'(bus.bank_done_ready), 32'h0000_FFFF);
      check("mid_valid",    32'(bus.request_done_valid), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
